// File: rtl/sort_floats_streamer.sv
// Sequential three-float sorter: accepts one triple, sorts it through one shared
// comparator, streams the three results out. Define SORT_FLOATS_DESCENDING_EN for largest-first output.

module f_less_or_equal #(
    parameter int FLEN = 64
) (
    input  logic [FLEN-1:0] a_i,
    input  logic [FLEN-1:0] b_i,
    output logic            res_o,
    output logic            err_o
);
    localparam int EXP_W = (FLEN == 64) ? 11 : (FLEN == 32) ? 8 : 5;
    localparam int MAN_W = FLEN - 1 - EXP_W;

    logic            a_nan, b_nan, a_sign, b_sign, both_zero;
    logic [FLEN-2:0] a_mag, b_mag;

    always_comb begin
        a_sign    = a_i[FLEN-1];
        b_sign    = b_i[FLEN-1];
        a_mag     = a_i[FLEN-2:0];
        b_mag     = b_i[FLEN-2:0];
        a_nan     = (&a_i[FLEN-2 -: EXP_W]) && (|a_i[MAN_W-1:0]);
        b_nan     = (&b_i[FLEN-2 -: EXP_W]) && (|b_i[MAN_W-1:0]);
        both_zero = (a_mag == '0) && (b_mag == '0);
        err_o     = a_nan || b_nan;
        res_o     = 1'b0;
        // +0 and -0 compare equal, so a signed-zero pair is never reordered.
        if (err_o)                res_o = 1'b0;
        else if (both_zero)       res_o = 1'b1;
        else if (a_sign != b_sign) res_o = a_sign;
        else if (!a_sign)         res_o = (a_mag <= b_mag);
        else                      res_o = (a_mag >= b_mag);
    end
endmodule

module sort_floats_streamer #(
    parameter int FLEN = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 up_valid_i,
    output logic                 up_ready_o,
    input  logic [0:2][FLEN-1:0] up_data_i,
    output logic                 down_valid_o,
    input  logic                 down_ready_i,
    output logic [FLEN-1:0]      down_data_o,
    output logic                 down_last_o,
    output logic                 down_err_o
);
    typedef enum logic [2:0] {S_IDLE, S_C01, S_C12, S_C01B, S_EMIT} state_e;

    state_e                state_q, state_d;
    logic [0:2][FLEN-1:0]  r_q, r_d;
    logic                  err_acc_q, err_acc_d;
    logic [1:0]            idx_q, idx_d, sel;
    logic [FLEN-1:0]       cmp_a, cmp_b;
    logic                  cmp_res, cmp_err;

    f_less_or_equal #(.FLEN(FLEN)) u_cmp (
        .a_i   (cmp_a),
        .b_i   (cmp_b),
        .res_o (cmp_res),
        .err_o (cmp_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            err_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_acc_q <= err_acc_d;
        end
    end

    // NOTE: the operand registers carry no reset; outputs are gated by state, so stale contents never leak.
    always_ff @(posedge clk) begin
        r_q <= r_d;
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        err_acc_d = err_acc_q;
        idx_d     = idx_q;
        cmp_a     = r_q[0];
        cmp_b     = r_q[1];
        if (state_q == S_C12) begin
            cmp_a = r_q[1];
            cmp_b = r_q[2];
        end

        unique case (state_q)
            S_IDLE: begin
                if (up_valid_i) begin
                    r_d       = up_data_i;
                    err_acc_d = 1'b0;
                    state_d   = S_C01;
                end
            end
            S_C01, S_C01B: begin
                if (!cmp_res) begin
                    r_d[0] = r_q[1];
                    r_d[1] = r_q[0];
                end
                err_acc_d = err_acc_q | cmp_err;
                if (state_q == S_C01) begin
                    state_d = S_C12;
                end else begin
                    idx_d   = 2'd0;
                    state_d = S_EMIT;
                end
            end
            S_C12: begin
                if (!cmp_res) begin
                    r_d[1] = r_q[2];
                    r_d[2] = r_q[1];
                end
                err_acc_d = err_acc_q | cmp_err;
                state_d   = S_C01B;
            end
            S_EMIT: begin
                if (down_ready_i) begin
                    if (idx_q == 2'd2) state_d = S_IDLE;
                    else               idx_d   = idx_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SORT_FLOATS_DESCENDING_EN
    assign sel = 2'd2 - idx_q;
`else
    assign sel = idx_q;
`endif

    assign up_ready_o   = (state_q == S_IDLE);
    assign down_valid_o = (state_q == S_EMIT);
    assign down_data_o  = (state_q == S_EMIT) ? r_q[sel] : '0;
    assign down_last_o  = (state_q == S_EMIT) && (idx_q == 2'd2);
    assign down_err_o   = (state_q == S_EMIT) && err_acc_q;
endmodule
